// File: rtl/ysyx_2022040010_shift_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_2022040010_shift_iter_if
// Description : Request/response bundle for the iterative shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_2022040010_shift_iter_if #(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = $clog2(XLEN)
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    operand;
  logic [SHAMT_W-1:0] shamt;
  logic [2:0]         op;
  logic               word_mode;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    result;
  logic               busy;

  modport master (
    output flush, in_valid, operand, shamt, op, word_mode, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, operand, shamt, op, word_mode, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_2022040010_shift_iter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_2022040010_shift_iter
// Description : Multi-cycle SLL/SRL/SRA/ROL/ROR, at most STEP bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_2022040010_shift_iter #(
  parameter int XLEN = 64,
  parameter int STEP = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  ysyx_2022040010_shift_iter_if.slave   sif
);
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [2:0]         c_OP_SLL    = 3'd0;
  localparam logic [2:0]         c_OP_SRL    = 3'd1;
  localparam logic [2:0]         c_OP_SRA    = 3'd2;
  localparam logic [2:0]         c_OP_ROL    = 3'd3;
  localparam logic [2:0]         c_OP_ROR    = 3'd4;
  localparam logic [SHAMT_W-1:0] c_WORD_MSK  = SHAMT_W'(31);
  localparam logic [SHAMT_W-1:0] c_STEP_K   = SHAMT_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [SHAMT_W-1:0] r_rem, w_rem_nxt;
  logic [XLEN-1:0]    r_acc, w_acc_nxt;
  logic [2:0]         r_op, w_op_nxt;
  logic               r_word, w_word_nxt;
  logic [XLEN-1:0]    r_result, w_result_nxt;

  logic               w_word_in;
  logic [SHAMT_W-1:0] w_eff;
  logic [SHAMT_W-1:0] w_k;
  logic [XLEN-1:0]    w_step;
  logic               w_legal;

  // Word mode only exists on a 64-bit datapath.
  generate
    if (XLEN == 64) begin : g_word_en
      assign w_word_in = sif.word_mode;
    end else begin : g_word_dis
      assign w_word_in = 1'b0;
    end
  endgenerate

  // Word-mode steps keep a sign-extended 32-bit value, so a zero-distance
  // shift doubles as the final sign-extension.
  function automatic logic [XLEN-1:0] f_shift(
    input logic [XLEN-1:0]    v,
    input logic [SHAMT_W-1:0] k,
    input logic [2:0]         op,
    input logic               word
  );
    logic [31:0]     lo;
    logic [31:0]     r32;
    logic [XLEN-1:0] r;
    int              ki;
    lo  = v[31:0];
    ki  = int'(k);
    r32 = '0;
    r   = '0;
    case (op)
      c_OP_SLL: begin r32 = lo << k; r = v << k; end
      c_OP_SRL: begin r32 = lo >> k; r = v >> k; end
      c_OP_SRA: begin
        r32 = $unsigned($signed(lo) >>> k);
        r   = $unsigned($signed(v) >>> k);
      end
      c_OP_ROL: begin
        r32 = (lo << k) | (lo >> (32 - ki));
        r   = (v << k) | (v >> (XLEN - ki));
      end
      c_OP_ROR: begin
        r32 = (lo >> k) | (lo << (32 - ki));
        r   = (v >> k) | (v << (XLEN - ki));
      end
      default: begin r32 = '0; r = '0; end
    endcase
    f_shift = word ? XLEN'($signed(r32)) : r;
  endfunction

  assign w_legal = (sif.op <= c_OP_ROR);
  assign w_eff   = w_word_in ? (sif.shamt & c_WORD_MSK) : sif.shamt;
  assign w_k     = (int'(r_rem) > STEP) ? c_STEP_K : r_rem;
  assign w_step  = f_shift(r_acc, w_k, r_op, r_word);

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_acc_nxt    = r_acc;
    w_op_nxt     = r_op;
    w_word_nxt   = r_word;
    w_result_nxt = r_result;
    if (sif.flush) begin
      w_state_nxt = S_IDLE;
      w_rem_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sif.in_valid) begin
            w_op_nxt   = sif.op;
            w_word_nxt = w_word_in;
            w_acc_nxt  = sif.operand;
            if (!w_legal) begin
              w_state_nxt  = S_DONE;
              w_result_nxt = '0;
            end else if (w_eff == '0) begin
              w_state_nxt  = S_DONE;
              w_result_nxt = f_shift(sif.operand, '0, sif.op, w_word_in);
            end else begin
              w_state_nxt = S_BUSY;
              w_rem_nxt   = w_eff;
            end
          end
        end
        S_BUSY: begin
          w_acc_nxt = w_step;
          w_rem_nxt = r_rem - w_k;
          if (r_rem == w_k) begin
            w_state_nxt  = S_DONE;
            w_result_nxt = w_step;
          end
        end
        S_DONE: begin
          if (sif.out_ready) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_acc    <= '0;
      r_op     <= '0;
      r_word   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rem    <= w_rem_nxt;
      r_acc    <= w_acc_nxt;
      r_op     <= w_op_nxt;
      r_word   <= w_word_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign sif.in_ready  = (r_state == S_IDLE) && !rst;
  assign sif.out_valid = (r_state == S_DONE);
  assign sif.busy      = (r_state != S_IDLE);
  assign sif.result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_2022040010_shift_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_2022040010_shift_iter
// Description : Self-checking bench for the iterative shifter (XLEN=64, STEP=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_2022040010_shift_iter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   cmp_en = 1'b0;

  ysyx_2022040010_shift_iter_if #(.XLEN(64)) sif();

  ysyx_2022040010_shift_iter #(.XLEN(64), .STEP(8)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bit-by-bit definition of each operation over width W.
  function automatic logic [63:0] ref_shift(input logic [63:0] x, input int s, input int op, input bit w);
    int          wd;
    int          se;
    logic [63:0] r;
    wd = w ? 32 : 64;
    se = w ? (s % 32) : s;
    r  = '0;
    if (op > 4) return '0;
    for (int i = 0; i < wd; i++) begin
      case (op)
        0: r[i] = (i >= se) ? x[i-se] : 1'b0;
        1: r[i] = (i + se < wd) ? x[i+se] : 1'b0;
        2: r[i] = (i + se < wd) ? x[i+se] : x[wd-1];
        3: r[i] = x[(i - se + wd) % wd];
        default: r[i] = x[(i + se) % wd];
      endcase
    end
    if (w) for (int i = 32; i < 64; i++) r[i] = r[31];
    return r;
  endfunction

  function automatic int ref_lat(input int s, input int op, input bit w);
    int se;
    se = w ? (s % 32) : s;
    return (op > 4) ? 1 : 1 + (se + 7) / 8;
  endfunction

  // Transaction-level model: an accepted op becomes visible after its latency.
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  logic [63:0] m_res = '0;
  logic [63:0] m_next = '0;
  int          m_cnt = 0;
  int          m_accepts = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_valid = 1'b0; m_res = '0; m_cnt = 0;
    end else if (sif.flush) begin
      m_busy = 1'b0; m_valid = 1'b0;
    end else if (m_valid) begin
      if (sif.out_ready) begin m_valid = 1'b0; m_busy = 1'b0; end
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin m_valid = 1'b1; m_res = m_next; end
    end else if (sif.in_valid) begin
      m_next = ref_shift(sif.operand, int'(sif.shamt), int'(sif.op), sif.word_mode);
      m_cnt  = ref_lat(int'(sif.shamt), int'(sif.op), sif.word_mode) - 1;
      m_busy = 1'b1;
      m_accepts++;
      if (m_cnt == 0) begin m_valid = 1'b1; m_res = m_next; end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", 64'(sif.out_valid), 64'(m_valid));
      chk("busy", 64'(sif.busy), 64'(m_busy));
      chk("in_ready", 64'(sif.in_ready), 64'(!m_busy && !rst));
      chk("result", sif.result, m_res);
    end
  end

  task automatic scramble();
    sif.operand   = {$urandom, $urandom};
    sif.shamt     = 6'($urandom);
    sif.op        = 3'($urandom);
    sif.word_mode = 1'($urandom);
  endtask

  task automatic accept(input logic [63:0] x, input logic [5:0] s, input logic [2:0] o, input logic w);
    int g = 0;
    @(negedge clk);
    while (!sif.in_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
    end
    #1;
    sif.operand = x; sif.shamt = s; sif.op = o; sif.word_mode = w; sif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    scramble();
  endtask

  task automatic expect_result(input string name, input logic [63:0] exp, input int exp_lat, input int hold);
    int lat = 1;
    @(negedge clk);
    while (!sif.out_valid && lat < 64) begin @(negedge clk); lat++; end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_result"}, sif.result, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_in_ready"}, 64'(sif.in_ready), 64'd0);
      chk({name, "_hold_result"}, sif.result, exp);
    end
    #1 sif.out_ready = 1'b1;
    @(posedge clk);
    #1 sif.out_ready = 1'b0;
  endtask

  initial begin
    bit saw_valid;
    sif.flush = 1'b0; sif.in_valid = 1'b0; sif.out_ready = 1'b0;
    scramble();
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(sif.in_ready), 64'd0);
    chk("reset_busy", 64'(sif.busy), 64'd0);
    chk("reset_out_valid", 64'(sif.out_valid), 64'd0);
    chk("reset_result", sif.result, 64'd0);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    accept(64'h1, 6'd63, 3'd0, 1'b0);
    expect_result("sll63", 64'h8000_0000_0000_0000, 9, 0);
    accept(64'h8000_0000_0000_0000, 6'd4, 3'd2, 1'b0);
    expect_result("sra4", 64'hF800_0000_0000_0000, 2, 0);
    accept(64'h8000_0000_0000_0000, 6'd4, 3'd1, 1'b0);
    expect_result("srl4", 64'h0800_0000_0000_0000, 2, 0);
    accept(64'h0000_0000_8000_0000, 6'h24, 3'd2, 1'b1);
    expect_result("sraw", 64'hFFFF_FFFF_F800_0000, 2, 0);
    accept(64'hFFFF_FFFF_8000_0000, 6'd4, 3'd1, 1'b1);
    expect_result("srlw", 64'h0000_0000_0800_0000, 2, 0);
    accept(64'h0123_4567_89AB_CDEF, 6'd16, 3'd4, 1'b0);
    expect_result("ror16", 64'hCDEF_0123_4567_89AB, 3, 0);
    accept(64'h8000_0001, 6'd1, 3'd3, 1'b1);
    expect_result("rolw", 64'h3, 2, 0);
    accept(64'h5, 6'd0, 3'd0, 1'b0);
    expect_result("shamt0", 64'h5, 1, 5);
    accept(64'hFFFF, 6'd20, 3'd7, 1'b0);
    expect_result("illegal", 64'h0, 1, 0);

    // Flush on the second BUSY edge.
    accept(64'h1, 6'd63, 3'd0, 1'b0);
    @(posedge clk);
    #1 sif.flush = 1'b1;
    @(posedge clk);
    #1 sif.flush = 1'b0;
    chk("flush_busy", 64'(sif.busy), 64'd0);
    chk("flush_in_ready", 64'(sif.in_ready), 64'd1);
    saw_valid = 1'b0;
    repeat (12) begin @(negedge clk); if (sif.out_valid) saw_valid = 1'b1; end
    chk("flush_no_valid", 64'(saw_valid), 64'd0);
    accept(64'h5, 6'd3, 3'd0, 1'b0);
    expect_result("after_flush", 64'h28, 2, 0);

    // Asynchronous reset in the middle of BUSY.
    accept(64'h1, 6'd63, 3'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 64'(sif.in_ready), 64'd0);
    chk("rst_mid_busy", 64'(sif.busy), 64'd0);
    chk("rst_mid_result", sif.result, 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_release_in_ready", 64'(sif.in_ready), 64'd1);
    saw_valid = 1'b0;
    repeat (12) begin @(negedge clk); if (sif.out_valid) saw_valid = 1'b1; end
    chk("rst_no_valid", 64'(saw_valid), 64'd0);
    accept(64'h0123_4567_89AB_CDEF, 6'd16, 3'd4, 1'b0);
    expect_result("after_rst", 64'hCDEF_0123_4567_89AB, 3, 0);

    // Random traffic, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      scramble();
      if ($urandom_range(0, 9) == 0) sif.shamt = ($urandom_range(0, 1) != 0) ? 6'd63 : 6'd0;
      if ($urandom_range(0, 3) == 0) sif.op = 3'($urandom_range(0, 4));
      sif.in_valid  = ($urandom_range(0, 1) != 0);
      sif.out_ready = ($urandom_range(0, 9) < 6);
      sif.flush     = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    #1 sif.in_valid = 1'b0; sif.flush = 1'b0; sif.out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("random_accepts_enough", 64'(m_accepts > 150), 64'd1);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
